// File: rtl/ctrl_lanceur.sv
// Dice launcher sequencer: die-type selection, free-running roll counter,
// and the SELECT -> ROLL -> SHOW sequence paced by an external tick.
module ctrl_lanceur #(
  parameter int unsigned ROLL_TICKS = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BP_Next,
  input  logic       BP_Prev,
  input  logic       BP_Lance,
  input  logic       Tick,
  output logic [6:0] NB_Face,
  output logic [6:0] Result,
  output logic       Result_Valid,
  output logic       Busy,
  output logic       Aff_Sel
);

  typedef enum logic [1:0] {
    S_SELECT,
    S_ROLL,
    S_SHOW
  } state_t;

  localparam logic [7:0] LP_LAST_TICK = 8'(ROLL_TICKS - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_idx;
  logic [2:0] w_idx_next;
  logic [6:0] r_nb_face;
  logic [6:0] r_cnt;
  logic [6:0] r_result;
  logic [7:0] r_tick_cnt;
  logic       w_roll_start;
  logic       w_tick_take;

  function automatic logic [6:0] face_of(input logic [2:0] idx);
    case (idx)
      3'd0:    face_of = 7'd4;
      3'd1:    face_of = 7'd6;
      3'd2:    face_of = 7'd8;
      3'd3:    face_of = 7'd10;
      3'd4:    face_of = 7'd12;
      3'd5:    face_of = 7'd20;
      3'd6:    face_of = 7'd30;
      default: face_of = 7'd100;
    endcase
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_roll_start = 1'b0;
    w_tick_take  = 1'b0;
    case (r_state)
      S_SELECT: begin
        if (BP_Lance) begin
          w_state_next = S_ROLL;
          w_roll_start = 1'b1;
        end else if (BP_Next && !BP_Prev) begin
          w_idx_next = r_idx + 3'd1;
        end else if (BP_Prev && !BP_Next) begin
          w_idx_next = r_idx - 3'd1;
        end
      end
      S_ROLL: begin
        if (Tick) begin
          w_tick_take = 1'b1;
          if (r_tick_cnt == LP_LAST_TICK) begin
            w_state_next = S_SHOW;
          end
        end
      end
      S_SHOW: begin
        // A selection press here only leaves the result screen; Idx stays put.
        if (BP_Lance) begin
          w_state_next = S_ROLL;
          w_roll_start = 1'b1;
        end else if (BP_Next || BP_Prev) begin
          w_state_next = S_SELECT;
        end
      end
      default: w_state_next = S_SELECT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_SELECT;
      r_idx      <= '0;
      r_nb_face  <= 7'd4;
      r_cnt      <= 7'd1;
      r_result   <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      // Decode from the next index so the new face count appears on the press edge.
      r_nb_face <= face_of(w_idx_next);
      r_cnt     <= (r_cnt >= r_nb_face) ? 7'd1 : r_cnt + 7'd1;
      if (w_roll_start) begin
        r_tick_cnt <= '0;
      end else if (w_tick_take) begin
        r_tick_cnt <= r_tick_cnt + 8'd1;
      end
      if (w_tick_take) begin
        r_result <= r_cnt;
      end
    end
  end

  assign NB_Face      = r_nb_face;
  assign Result       = r_result;
  assign Busy         = (r_state == S_ROLL);
  assign Result_Valid = (r_state == S_SHOW);
  assign Aff_Sel      = (r_state != S_SELECT);

endmodule

// File: tb/tb_ctrl_lanceur.sv
// Directed bench for ctrl_lanceur with ROLL_TICKS = 4; expected values are
// hand-derived from the die table and the post-reset counter sequence.
module tb_ctrl_lanceur;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BP_Next = 1'b0;
  logic       BP_Prev = 1'b0;
  logic       BP_Lance = 1'b0;
  logic       Tick = 1'b0;
  logic [6:0] NB_Face;
  logic [6:0] Result;
  logic       Result_Valid;
  logic       Busy;
  logic       Aff_Sel;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cyc_rst = 0;
  int   ticks_in_roll = 0;
  bit   exact = 1'b0;
  logic [6:0] last_res;

  ctrl_lanceur #(.ROLL_TICKS(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .BP_Next      (BP_Next),
    .BP_Prev      (BP_Prev),
    .BP_Lance     (BP_Lance),
    .Tick         (Tick),
    .NB_Face      (NB_Face),
    .Result       (Result),
    .Result_Valid (Result_Valid),
    .Busy         (Busy),
    .Aff_Sel      (Aff_Sel)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive for one edge, then look at outputs 1 time unit after it.
  task automatic step(input logic n, input logic p, input logic l, input logic t, input logic r);
    BP_Next = n; BP_Prev = p; BP_Lance = l; Tick = t; RST = r;
    @(posedge CLK);
    #1;
    BP_Next = 0; BP_Prev = 0; BP_Lance = 0; Tick = 0; RST = 0;
    cyc++;
    if (r) cyc_rst = cyc;
  endtask

  task automatic idle(input int k);
    repeat (k) step(0, 0, 0, 0, 0);
  endtask

  task automatic start_roll(input int nb);
    step(0, 0, 1, 0, 0);
    ticks_in_roll = 0;
    check_eq("start_busy", Busy, 1);
    check_eq("start_valid", Result_Valid, 0);
    check_eq("start_aff", Aff_Sel, 1);
    check_eq("start_nb", NB_Face, nb);
    last_res = Result;
  endtask

  // Each tick preceded by gap-1 idle cycles; poke fires Next, Prev, Lance into ROLL.
  task automatic ticks(input int n, input int gap, input int nb, input bit poke);
    for (int k = 0; k < n; k++) begin
      for (int j = 1; j < gap; j++) begin
        step(poke && j == 1, poke && j == 2, poke && j == 3, 0, 0);
        check_eq("roll_busy", Busy, 1);
        check_eq("roll_hold", Result, last_res);
        check_eq("roll_nb", NB_Face, nb);
      end
      step(0, 0, 0, 1, 0);
      ticks_in_roll++;
      check_eq("res_range", (Result >= 1 && Result <= nb), 1);
      if (exact) check_eq("res_exact", Result, ((cyc - cyc_rst - 1) % 4) + 1);
      check_eq("tick_busy", Busy, ticks_in_roll < 4);
      check_eq("tick_valid", Result_Valid, ticks_in_roll >= 4);
      last_res = Result;
    end
  endtask

  initial begin
    int faces[8];
    int waits[4];
    faces = '{6, 8, 10, 12, 20, 30, 100, 4};
    waits = '{7, 20, 50, 93};

    // Reset values and selection wrap
    step(0, 0, 0, 0, 1);
    check_eq("rst_nb", NB_Face, 4);
    check_eq("rst_result", Result, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_valid", Result_Valid, 0);
    check_eq("rst_aff", Aff_Sel, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 0);
      check_eq("next_nb", NB_Face, faces[i]);
    end
    step(0, 1, 0, 0, 0);
    check_eq("prev_wrap", NB_Face, 100);

    // Simultaneous buttons in SELECT
    step(1, 1, 0, 0, 0);
    check_eq("both_nb", NB_Face, 100);
    check_eq("both_busy", Busy, 0);
    step(1, 0, 1, 0, 0);
    ticks_in_roll = 0;
    check_eq("lance_pri_busy", Busy, 1);
    check_eq("lance_pri_nb", NB_Face, 100);
    last_res = Result;
    ticks(4, 3, 100, 1'b0);
    idle(3);
    check_eq("show_valid", Result_Valid, 1);
    check_eq("show_hold", Result, last_res);

    // Leaving SHOW with Next keeps the die
    step(1, 0, 0, 0, 0);
    check_eq("exit_aff", Aff_Sel, 0);
    check_eq("exit_nb", NB_Face, 100);
    check_eq("exit_valid", Result_Valid, 0);

    // Full d6 roll with ignored buttons during ROLL
    step(1, 0, 0, 0, 0);
    check_eq("sel_d4", NB_Face, 4);
    step(1, 0, 0, 0, 0);
    check_eq("sel_d6", NB_Face, 6);
    start_roll(6);
    ticks(4, 10, 6, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      check_eq("d6_hold", Result, last_res);
      check_eq("d6_valid", Result_Valid, 1);
    end

    // Shrink from d100 to d6 at several counter phases, back-to-back ticks
    foreach (waits[w]) begin
      step(1, 0, 0, 0, 0);
      check_eq("shr_exit", Aff_Sel, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      check_eq("shr_d100", NB_Face, 100);
      idle(waits[w]);
      repeat (6) step(0, 1, 0, 0, 0);
      check_eq("shr_d6", NB_Face, 6);
      start_roll(6);
      ticks(4, 1, 6, 1'b0);
    end

    // Relaunch from SHOW goes straight to ROLL
    start_roll(6);
    ticks(2, 10, 6, 1'b0);

    // Reset mid-roll, then a tick coinciding with the launch is not counted
    step(0, 0, 0, 1, 1);
    check_eq("mid_rst_nb", NB_Face, 4);
    check_eq("mid_rst_result", Result, 0);
    check_eq("mid_rst_busy", Busy, 0);
    check_eq("mid_rst_aff", Aff_Sel, 0);
    check_eq("mid_rst_valid", Result_Valid, 0);
    step(0, 0, 1, 1, 0);
    ticks_in_roll = 0;
    check_eq("relaunch_busy", Busy, 1);
    check_eq("relaunch_result", Result, 0);
    last_res = Result;
    exact = 1'b1;
    ticks(4, 10, 4, 1'b1);
    exact = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
